bus_arbiter_rr2: RTL
====================

// Module: bus_arbiter_rr2
// PURPOSE
//   Two-requester round-robin arbiter for one shared WIDTH-bit write path.
//   Grants one requester at a time, drives the 2:1 data select and presents the
//   winner's word on the shared bus until the downstream resource signals done.
//   Sits between the two producers and the shared register/memory port.
// PARAMETERS
//   WIDTH           32  data word width
//   TIMEOUT_CYCLES  16  max BUSY cycles before forced release (only with ARB_TIMEOUT_EN); >=2
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req0       in   1      requester 0 request; held high until its transaction completes
//   req1       in   1      requester 1 request; same rule
//   data0      in   WIDTH  requester 0 write word
//   data1      in   WIDTH  requester 1 write word
//   done       in   1      shared resource completed current transaction (sampled in BUSY only)
//   gnt0       out  1      grant to requester 0 (registered)
//   gnt1       out  1      grant to requester 1 (registered)
//   mux_sel    out  1      data select: 0=data0, 1=data1 (registered)
//   bus_valid  out  1      gnt0|gnt1
//   bus_data   out  WIDTH  mux_sel ? data1 : data0 (combinational from registered select)
//   timeout    out  1      one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, gnt0=gnt1=0, mux_sel=0, timeout=0,
//     last_gnt=1 (so requester 0 wins the first simultaneous request).
//   - States: IDLE, BUSY0, BUSY1. gnt0=(state==BUSY0), gnt1=(state==BUSY1); never both.
//   - IDLE: req0 or req1 sampled -> next cycle BUSYx; latency req->gnt = 1 cycle.
//     Both high: grant the one != last_gnt. Neither: stay IDLE, mux_sel holds.
//   - BUSYx: hold grant, mux_sel, counter while done=0; req changes ignored.
//   - BUSYx with done=1: last_gnt<=x; next state chosen in same edge, no idle bubble:
//     other requester high -> BUSY(other); else req_x high -> BUSYx (re-grant);
//     else IDLE. mux_sel updates with the grant.
//   - done while IDLE: ignored. done held high: each BUSY cycle completes one transaction.
//   - rst_n asserted mid-transaction: grant drops immediately (async), pointer reset.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined: cycle counter cleared on entry to any BUSY state,
//     increments each BUSY cycle with done=0; when it reaches TIMEOUT_CYCLES-1 with
//     done=0, release exactly as a done (same next-state rules) and pulse timeout=1
//     for one cycle coincident with the new state. done and expiry same cycle: done wins, no pulse.
//   ARB_TIMEOUT_EN undefined: no counter logic; timeout tied 0; grant held
//     indefinitely until done.
// STRUCTURE
//   Shared package/include arb_pkg: state encodings (IDLE=2'd0, BUSY0=2'd1,
//   BUSY1=2'd2), counter width derived via $clog2(TIMEOUT_CYCLES).
//   One sub-module: rr2_pick (combinational: req0, req1, last_gnt -> winner, any).
//   Data select reuses the team's existing 32-bit 2:1 mux instance.
// TESTING
//   1 Reset, req0=1 only, data0=32'hDEADBEEF -> cycle+1 gnt0=1, mux_sel=0, bus_data=DEADBEEF.
//   2 req0=req1=1 from reset, done pulsed every 3rd cycle -> grants alternate 0,1,0,1;
//     bus_data alternates data0/data1 with no IDLE cycle between.
//   3 Only req1 held, done=1 every cycle -> gnt1 stays 1, one transaction per cycle.
//   4 rst_n low for 1 cycle while BUSY1 -> gnt1=0 in same cycle (async), IDLE after;
//     next simultaneous request grants requester 0.
//   5 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, req0=req1=1, done=0 -> gnt0 for 4 cycles,
//     timeout pulse, then gnt1; undefined build: gnt0 held 100 cycles, timeout=0.
//   6 done asserted while IDLE -> no grant, no state change; assert never gnt0&gnt1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter:
// state encodings and the timeout counter width helper.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } arb_state_e;

    // The counter must hold TIMEOUT_CYCLES-1 as its terminal value.
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles <= 2) ? 1 : $clog2(timeout_cycles);
    endfunction

endpackage

// File: rtl/mux2.sv
// Generic 2:1 data select used for the shared write path.
module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/rr2_pick.sv
// Round-robin winner pick for two requesters: on contention the requester
// that did not hold the bus last wins; otherwise the sole requester wins.
module rr2_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_gnt_i,
    output logic winner_o,
    output logic any_o
);

    assign any_o    = req0_i | req1_i;
    assign winner_o = (req0_i & req1_i) ? ~last_gnt_i : req1_i;

endmodule

// File: rtl/bus_arbiter_rr2.sv
// Two-requester round-robin arbiter driving a shared WIDTH-bit write path.
// Optional forced release after TIMEOUT_CYCLES busy cycles with ARB_TIMEOUT_EN.
module bus_arbiter_rr2
    import arb_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             done,
    output logic             gnt0,
    output logic             gnt1,
    output logic             mux_sel,
    output logic             bus_valid,
    output logic [WIDTH-1:0] bus_data,
    output logic             timeout
);

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       mux_sel_q, mux_sel_d;
    logic       busy, cur, release_now, expire;
    logic       pick_last, winner, any;

    assign busy = (state_q == ST_BUSY0) || (state_q == ST_BUSY1);
    assign cur  = (state_q == ST_BUSY1);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign expire = busy && !done && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    // A completed transaction or re-grant starts a fresh count.
    assign cnt_d     = (busy && !release_now) ? cnt_q + 1'b1 : '0;
    assign timeout_d = release_now && expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign release_now = busy && (done || expire);
    // Seeding the picker with the finishing owner yields "other first, then
    // re-grant, else idle" from the same round-robin rule used in IDLE.
    assign pick_last = release_now ? cur : last_gnt_q;

    rr2_pick u_pick (
        .req0_i     (req0),
        .req1_i     (req1),
        .last_gnt_i (pick_last),
        .winner_o   (winner),
        .any_o      (any)
    );

    // NOTE: every signal is defaulted first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        mux_sel_d  = mux_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d   = winner ? ST_BUSY1 : ST_BUSY0;
                    mux_sel_d = winner;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (release_now) begin
                    last_gnt_d = cur;
                    if (any) begin
                        state_d   = winner ? ST_BUSY1 : ST_BUSY0;
                        mux_sel_d = winner;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
            mux_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            mux_sel_q  <= mux_sel_d;
        end
    end

    assign gnt0      = (state_q == ST_BUSY0);
    assign gnt1      = (state_q == ST_BUSY1);
    assign mux_sel   = mux_sel_q;
    assign bus_valid = gnt0 | gnt1;

    mux2 #(.WIDTH(WIDTH)) u_data_mux (
        .sel_i (mux_sel_q),
        .a_i   (data0),
        .b_i   (data1),
        .y_o   (bus_data)
    );

endmodule
